// File: rtl/resp_sig_chk_pkg.sv
// Shared definitions for the response signature checker: FSM state
// encodings and the default MISR polynomial / seed.
package resp_sig_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

endpackage

// File: rtl/resp_sig_chk_misr_step.sv
// One combinational MISR step: shift left, fold the polynomial back in
// when the outgoing MSB is set, then XOR the zero-extended sample.
module misr_step #(
  parameter int               WIDTH = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic [WIDTH-1:0] i_din,
  output logic [SIG_W-1:0] o_sig_n
);

  logic [SIG_W-1:0] w_din_ext;
  logic [SIG_W-1:0] w_fb;

  // Zero-extend the sample into the low bits and select feedback taps.
  always_comb begin
    w_din_ext              = '0;
    w_din_ext[WIDTH-1:0]   = i_din;
    w_fb                   = i_sig[SIG_W-1] ? POLY : '0;
    o_sig_n                = {i_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ w_din_ext;
  end

endmodule

// File: rtl/resp_sig_chk.sv
// Response checker: compacts NSAMP valid samples into a MISR signature,
// then compares against exp_sig and holds done/pass until the next start.
//
// Handshake: din is consumed on every rising edge in RUN where
// din_valid=1; there is no back-pressure, the checker is always ready
// while busy. start is honoured only in IDLE and DONE.
module resp_sig_chk
  import resp_sig_chk_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
  parameter int               NSAMP = 16,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSAMP - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_n;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_pass;
  logic             w_accept;

  misr_step #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr_step (
    .i_sig   (r_sig),
    .i_din   (din),
    .o_sig_n (w_sig_n)
  );

  assign w_accept = (r_state == ST_RUN) && din_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state: leave RUN on the edge that takes the last sample.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_n = ST_RUN;
      ST_RUN:  if (w_accept && (r_cnt == LAST_IDX)) w_state_n = ST_CMP;
      ST_CMP:  w_state_n = ST_DONE;
      ST_DONE: if (start) w_state_n = ST_RUN;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Datapath: signature, sample counter and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig  <= SEED;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_sig  <= SEED;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
          end
        end
        ST_RUN: begin
          if (din_valid) begin
            r_sig <= w_sig_n;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CMP: begin
          r_pass <= (r_sig == exp_sig);
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_CMP);
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;
  assign count     = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_resp_sig_chk.sv
// Bench for resp_sig_chk. Three instances share clk/rst:
//   ua: WIDTH=1, NSAMP=1            (single-sample runs)
//   ub: WIDTH=1, SEED=0, NSAMP=4    (sparse valid, saturation)
//   uc: WIDTH=4, NSAMP=16           (reset abort, start handling, sweep)
// uc is tracked every cycle by a transaction-level model.
module tb_resp_sig_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // instance a
  logic        a_start = 0, a_valid = 0;
  logic [0:0]  a_din = '0;
  logic [15:0] a_exp = '0;
  logic        a_busy, a_done, a_pass;
  logic [15:0] a_sig;
  logic [7:0]  a_cnt;
  logic [1:0]  a_st;
  // instance b
  logic        b_start = 0, b_valid = 0;
  logic [0:0]  b_din = '0;
  logic [15:0] b_exp = '0;
  logic        b_busy, b_done, b_pass;
  logic [15:0] b_sig;
  logic [7:0]  b_cnt;
  logic [1:0]  b_st;
  // instance c
  logic        c_start = 0, c_valid = 0;
  logic [3:0]  c_din = '0;
  logic [15:0] c_exp = '0;
  logic        c_busy, c_done, c_pass;
  logic [15:0] c_sig;
  logic [7:0]  c_cnt;
  logic [1:0]  c_st;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  resp_sig_chk #(.WIDTH(1), .NSAMP(1)) ua (
    .clk(clk), .rst(rst), .start(a_start), .din_valid(a_valid), .din(a_din),
    .exp_sig(a_exp), .busy(a_busy), .done(a_done), .pass(a_pass),
    .signature(a_sig), .count(a_cnt), .dbg_state(a_st));

  resp_sig_chk #(.WIDTH(1), .SEED(16'h0000), .NSAMP(4)) ub (
    .clk(clk), .rst(rst), .start(b_start), .din_valid(b_valid), .din(b_din),
    .exp_sig(b_exp), .busy(b_busy), .done(b_done), .pass(b_pass),
    .signature(b_sig), .count(b_cnt), .dbg_state(b_st));

  resp_sig_chk #(.WIDTH(4), .NSAMP(16)) uc (
    .clk(clk), .rst(rst), .start(c_start), .din_valid(c_valid), .din(c_din),
    .exp_sig(c_exp), .busy(c_busy), .done(c_done), .pass(c_pass),
    .signature(c_sig), .count(c_cnt), .dbg_state(c_st));

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference MISR step as polynomial arithmetic over GF(2): multiply by x,
  // reduce by the full 17-bit polynomial, add the sample.
  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [3:0] d);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h1_1021;
    return t[15:0] ^ {12'h000, d};
  endfunction

  // ---------------- model of uc ----------------
  // A run is: collecting samples, then one compare cycle, then a held result.
  logic        m_collect = 0, m_judge = 0, m_done = 0, m_pass = 0;
  logic [15:0] m_sig = 16'hFFFF;
  int          m_taken = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_collect <= 0; m_judge <= 0; m_done <= 0; m_pass <= 0;
      m_sig <= 16'hFFFF; m_taken <= 0;
    end else if (m_judge) begin
      m_pass  <= (m_sig == c_exp);
      m_done  <= 1;
      m_judge <= 0;
    end else if (m_collect) begin
      if (c_valid) begin
        m_sig   <= ref_step(m_sig, c_din);
        m_taken <= m_taken + 1;
        if (m_taken + 1 == 16) begin
          m_collect <= 0;
          m_judge   <= 1;
        end
      end
    end else if (c_start) begin
      m_collect <= 1; m_sig <= 16'hFFFF; m_taken <= 0;
      m_done <= 0; m_pass <= 0;
    end
  end

  // Compare uc against the model on every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("c_busy", c_busy, m_collect || m_judge);
      chk("c_done", c_done, m_done);
      chk("c_sig", c_sig, m_sig);
      chk("c_count", c_cnt, m_taken);
      chk("c_state", c_st, m_collect ? 2 'd1 : m_judge ? 2'd2 : m_done ? 2'd3 : 2'd0);
      if (m_done) chk("c_pass", c_pass, m_pass);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_c_done(input int budget);
    int n = 0;
    while (!c_done && n < budget) begin
      tick();
      n++;
    end
    chk("c_done_timeout", c_done, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] golden;

  initial begin
    // Reference model pinned to hand-computed single steps.
    chk("model_pin_din1", ref_step(16'hFFFF, 4'd1), 16'hEFDE);
    chk("model_pin_din0", ref_step(16'hFFFF, 4'd0), 16'hEFDF);

    // Test 1: reset
    tick(); tick();
    chk("rst_busy", c_busy, 0);
    chk("rst_done", c_done, 0);
    chk("rst_pass", c_pass, 0);
    chk("rst_count", c_cnt, 0);
    chk("rst_sig", c_sig, 16'hFFFF);
    chk("rst_a_sig", a_sig, 16'hFFFF);
    chk("rst_b_sig", b_sig, 16'h0000);
    rst = 0;
    chk_en = 1;

    // Test 2: NSAMP=1, din=1 -> EFDE, pass
    a_start = 1; tick();
    a_start = 0; a_valid = 1; a_din = 1; a_exp = 16'hEFDE; tick();
    chk("t2_sig", a_sig, 16'hEFDE);
    chk("t2_busy_cmp", a_busy, 1);
    chk("t2_done_early", a_done, 0);
    a_valid = 0; tick();
    chk("t2_done", a_done, 1);
    chk("t2_pass", a_pass, 1);
    chk("t2_busy", a_busy, 0);
    tick();
    chk("t2_done_held", a_done, 1);

    // Test 3: restart from DONE, din=0 -> EFDF, fail
    a_start = 1; tick();
    a_start = 0;
    chk("t3_done_clr", a_done, 0);
    chk("t3_pass_clr", a_pass, 0);
    chk("t3_sig_seed", a_sig, 16'hFFFF);
    a_valid = 1; a_din = 0; tick();
    chk("t3_sig", a_sig, 16'hEFDF);
    a_valid = 0; tick();
    chk("t3_done", a_done, 1);
    chk("t3_pass", a_pass, 0);

    // Test 4: SEED=0, NSAMP=4, valid every other cycle
    b_start = 1; tick();
    b_start = 0; b_din = 0; b_exp = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      b_valid = (i % 2 == 1);
      tick();
      chk("t4_count", b_cnt, (i + 1) / 2);
      chk("t4_sig", b_sig, 16'h0000);
    end
    b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_count_sat", b_cnt, 4);
    end
    chk("t4_done", b_done, 1);
    chk("t4_pass", b_pass, 1);
    b_valid = 0;

    // Test 5: reset mid-run on uc
    c_start = 1; tick();
    c_start = 0; c_valid = 1; c_din = 4'h5; tick(); tick();
    chk("t5_count2", c_cnt, 2);
    c_valid = 0; rst = 1; tick();
    rst = 0;
    chk("t5_busy", c_busy, 0);
    chk("t5_count", c_cnt, 0);
    chk("t5_sig", c_sig, 16'hFFFF);
    chk("t5_done", c_done, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_no_done", c_done, 0);
    end

    // Test 6: start in RUN ignored; start in DONE restarts
    c_start = 1; tick();
    c_start = 0; c_exp = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      c_valid = 1; c_din = 4'(i * 3);
      c_start = (i == 1);
      tick();
      if (i < 3) chk("t6_count_run", c_cnt, i + 1);
    end
    c_valid = 0; c_start = 0;
    wait_c_done(10);
    c_start = 1; c_valid = 1; c_din = 4'hF; tick();
    c_start = 0; c_valid = 0;
    chk("t6_restart_done", c_done, 0);
    chk("t6_restart_pass", c_pass, 0);
    chk("t6_restart_cnt", c_cnt, 0);
    chk("t6_restart_sig", c_sig, 16'hFFFF);

    // Exhaustive 4-bit sweep with correct expected signature -> pass
    golden = 16'hFFFF;
    for (int v = 0; v < 16; v++) golden = ref_step(golden, 4'(v));
    c_exp = golden;
    for (int v = 0; v < 16; v++) begin
      c_valid = 1; c_din = 4'(v); tick();
    end
    c_valid = 0;
    wait_c_done(10);
    chk("sweep_pass", c_pass, 1);
    chk("sweep_sig", c_sig, golden);

    // Same sweep, expected signature off by one bit -> fail
    c_start = 1; tick();
    c_start = 0; c_exp = golden ^ 16'h0001;
    for (int v = 0; v < 16; v++) begin
      c_valid = (v % 3 != 2) || 1'b1; c_din = 4'(v); tick();
    end
    c_valid = 0;
    wait_c_done(10);
    chk("sweep_fail", c_pass, 0);
    tick(); tick();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
